// File: rtl/arp_ctrl.sv
// ARP sequencer: answers ARP requests, resolves one IP to a MAC through a single-entry cache,
// and shares the arp_tx engine between replies (higher priority) and resolution requests.
module arp_ctrl #(
   parameter int TIMEOUT_CYC = 125_000_000,
   parameter int RETRY_MAX   = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        arp_rx_done,
   input  logic        arp_rx_type,
   input  logic [47:0] src_mac,
   input  logic [31:0] src_ip,
   input  logic        resolve_req,
   input  logic [31:0] resolve_ip,
   output logic        resolve_done,
   output logic        resolve_ok,
   output logic [47:0] resolve_mac,
   output logic        arp_tx_en,
   output logic        arp_tx_type,
   output logic [47:0] des_mac,
   output logic [31:0] des_ip,
   input  logic        arp_tx_done,
   output logic        cache_valid,
   output logic [31:0] cache_ip,
   output logic [47:0] cache_mac
);

   localparam int TW = $clog2(TIMEOUT_CYC);
   localparam int RW = $clog2(RETRY_MAX + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [RW-1:0] RETRY_LAST = RW'(RETRY_MAX);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] TX_RPL = 2'd1;
   localparam logic [1:0] TX_REQ = 2'd2;
   localparam logic [1:0] WAIT   = 2'd3;

   logic [1:0]    state_reg;
   logic [1:0]    ret_reg;
   logic [TW-1:0] timer_reg;
   logic [RW-1:0] retry_reg;
   logic          reply_pend_reg;
   logic          res_pend_reg;
   logic [47:0]   rpl_mac_reg;
   logic [31:0]   rpl_ip_reg;
   logic [31:0]   target_ip_reg;

   logic res_active;
   logic cache_hit;
   logic target_reply;
   logic timer_last;
   logic do_reply;
   logic do_req;

   // A reply serviced from WAIT still belongs to an active resolution.
   assign res_active   = (state_reg == TX_REQ) || (state_reg == WAIT) ||
                         ((state_reg == TX_RPL) && (ret_reg == WAIT));
   assign cache_hit    = cache_valid && (cache_ip == target_ip_reg);
   assign target_reply = arp_rx_done && arp_rx_type && (src_ip == target_ip_reg);
   assign timer_last   = (timer_reg == TIMER_LAST);

   always_comb begin
      do_reply = 1'b0;
      do_req   = 1'b0;
      case (state_reg)
         IDLE: begin
            do_reply = reply_pend_reg;
            do_req   = !reply_pend_reg && res_pend_reg && !cache_hit;
         end
         WAIT: begin
            do_reply = !target_reply && reply_pend_reg;
            do_req   = !target_reply && !reply_pend_reg && timer_last &&
                       (retry_reg < RETRY_LAST);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         ret_reg        <= IDLE;
         timer_reg      <= '0;
         retry_reg      <= '0;
         reply_pend_reg <= 1'b0;
         res_pend_reg   <= 1'b0;
         rpl_mac_reg    <= '0;
         rpl_ip_reg     <= '0;
         target_ip_reg  <= '0;
         resolve_done   <= 1'b0;
         resolve_ok     <= 1'b0;
         resolve_mac    <= '0;
         arp_tx_en      <= 1'b0;
         arp_tx_type    <= 1'b0;
         des_mac        <= '0;
         des_ip         <= '0;
         cache_valid    <= 1'b0;
         cache_ip       <= '0;
         cache_mac      <= '0;
      end else begin
         arp_tx_en    <= 1'b0;
         resolve_done <= 1'b0;

         if (arp_rx_done) begin
            cache_valid <= 1'b1;
            cache_ip    <= src_ip;
            cache_mac   <= src_mac;
         end

         if (resolve_req && !res_pend_reg && !res_active) begin
            res_pend_reg  <= 1'b1;
            target_ip_reg <= resolve_ip;
         end

         if (do_reply) begin
            arp_tx_en      <= 1'b1;
            arp_tx_type    <= 1'b1;
            des_mac        <= rpl_mac_reg;
            des_ip         <= rpl_ip_reg;
            reply_pend_reg <= 1'b0;
            ret_reg        <= state_reg;
            state_reg      <= TX_RPL;
         end else if (do_req) begin
            arp_tx_en    <= 1'b1;
            arp_tx_type  <= 1'b0;
            des_mac      <= 48'hff_ff_ff_ff_ff_ff;
            des_ip       <= target_ip_reg;
            res_pend_reg <= 1'b0;
            retry_reg    <= (state_reg == IDLE) ? RW'(1) : retry_reg + RW'(1);
            state_reg    <= TX_REQ;
         end else begin
            case (state_reg)
               IDLE: begin
                  if (res_pend_reg) begin
                     res_pend_reg <= 1'b0;
                     resolve_done <= 1'b1;
                     resolve_ok   <= 1'b1;
                     resolve_mac  <= cache_mac;
                  end
               end
               TX_RPL: if (arp_tx_done) state_reg <= ret_reg;
               TX_REQ: begin
                  if (arp_tx_done) begin
                     timer_reg <= '0;
                     state_reg <= WAIT;
                  end
               end
               WAIT: begin
                  if (target_reply) begin
                     resolve_done <= 1'b1;
                     resolve_ok   <= 1'b1;
                     resolve_mac  <= src_mac;
                     state_reg    <= IDLE;
                  end else if (timer_last) begin
                     resolve_done <= 1'b1;
                     resolve_ok   <= 1'b0;
                     resolve_mac  <= '0;
                     state_reg    <= IDLE;
                  end else begin
                     timer_reg <= timer_reg + TW'(1);
                  end
               end
               default: state_reg <= IDLE;
            endcase
         end

         // Placed last so a request arriving in the reply-launch cycle is not lost.
         if (arp_rx_done && !arp_rx_type) begin
            reply_pend_reg <= 1'b1;
            rpl_mac_reg    <= src_mac;
            rpl_ip_reg     <= src_ip;
         end
      end
   end

endmodule
